// File: rtl/pe_param.sv
// pe_param: parametrised processing element.
// NUM_IN input FIFOs feed a single ALU. A configuration FSM selects the
// operand ports, an optional constant operand, an opcode, the output tag
// and a repeat count. Results leave as registered, one-cycle-valid tokens.
// Optional build macro PE_STATS_EN adds saturating fire/stall counters.
module pe_param #(
    parameter int DATA_W     = 32,
    parameter int TOK_W      = DATA_W + 4,
    parameter int NUM_IN     = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_POST   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*TOK_W-1:0] PE_Inport,
    input  logic [NUM_POST-1:0]     Post_PE_Bp,
    input  logic [32:0]             PE_Configure_Inport,
    output logic [TOK_W-1:0]        PE_Outport,
    output logic [NUM_IN-1:0]       Pre_PE_Bp,
    output logic                    PE_Done,
    output logic                    PE_Ovf
`ifdef PE_STATS_EN
    ,
    output logic [31:0]             PE_Fire_Cnt,
    output logic [31:0]             PE_Stall_Cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BP_LIMIT = CNT_W'(FIFO_DEPTH - 2);
    localparam logic [3:0]       OP_ACC   = 4'd11;

    typedef enum logic [1:0] {CFG_IDLE, CFG_CONST, RUN, DONE} state_t;

    state_t              state_reg;
    logic [1:0]          src_a_reg;
    logic [1:0]          src_b_reg;
    logic                use_const_reg;
    logic [4:0]          rep_reg;
    logic [3:0]          op_reg;
    logic [1:0]          tag_reg;
    logic [DATA_W-1:0]   const_reg;
    logic [DATA_W-1:0]   acc_reg;
    logic [4:0]          fire_cnt_reg;
    logic [TOK_W-1:0]    out_reg;
    logic                done_reg;
    logic                ovf_reg;

    logic                cfg_valid;
    logic                cfg_ctrl;
    logic                fire;
    logic                opnd_ready;
    logic                down_ready;

    // Port slots 0..3 always exist so a 2-bit source index never reads out of
    // range; ports beyond NUM_IN look permanently empty.
    logic [3:0][TOK_W-1:0] head_tok;
    logic [3:0]            empty;
    logic [3:0]            pop;
    logic [NUM_IN-1:0]     ovf_hit;

    assign cfg_valid = PE_Configure_Inport[32];
    // A control word is accepted in every state except while waiting for the constant.
    assign cfg_ctrl  = cfg_valid && (state_reg != CFG_CONST);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_port
            // A port is popped once even when it is both srcA and srcB.
            assign pop[gi] = fire && ((src_a_reg == 2'(gi)) ||
                                      (!use_const_reg && (src_b_reg == 2'(gi))));

            if (gi < NUM_IN) begin : g_fifo
                // Small FIFO with asynchronous head read so an arriving token
                // can fire in the very next cycle.
                logic [TOK_W-1:0] mem [FIFO_DEPTH];
                logic [PTR_W-1:0] wr_ptr_reg;
                logic [PTR_W-1:0] rd_ptr_reg;
                logic [CNT_W-1:0] count_reg;
                logic [CNT_W-1:0] count_next;
                logic             bp_reg;
                logic [TOK_W-1:0] in_tok;
                logic             push_req;
                logic             push;

                assign in_tok        = PE_Inport[gi*TOK_W +: TOK_W];
                assign push_req      = in_tok[TOK_W-1];
                assign push          = push_req && (count_reg != FULL_CNT);
                assign ovf_hit[gi]   = push_req && (count_reg == FULL_CNT);
                assign head_tok[gi]  = mem[rd_ptr_reg];
                assign empty[gi]     = (count_reg == '0);
                assign Pre_PE_Bp[gi] = bp_reg;

                // Occupancy after this edge's push/pop.
                always_comb begin
                    count_next = count_reg;
                    if (push && !pop[gi])
                        count_next = count_reg + 1'b1;
                    else if (!push && pop[gi])
                        count_next = count_reg - 1'b1;
                end

                // Token storage write; contents need no reset.
                always_ff @(posedge clk) begin
                    if (push && !cfg_ctrl)
                        mem[wr_ptr_reg] <= in_tok;
                end

                // Pointers, occupancy and registered backpressure (one slot of slack).
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        wr_ptr_reg <= '0;
                        rd_ptr_reg <= '0;
                        count_reg  <= '0;
                        bp_reg     <= 1'b1;
                    end else if (cfg_ctrl) begin
                        wr_ptr_reg <= '0;
                        rd_ptr_reg <= '0;
                        count_reg  <= '0;
                        bp_reg     <= 1'b1;
                    end else begin
                        if (push)
                            wr_ptr_reg <= wr_ptr_reg + 1'b1;
                        if (pop[gi])
                            rd_ptr_reg <= rd_ptr_reg + 1'b1;
                        count_reg <= count_next;
                        bp_reg    <= (count_next <= BP_LIMIT);
                    end
                end
            end else begin : g_absent
                assign head_tok[gi] = '0;
                assign empty[gi]    = 1'b1;
            end
        end
    endgenerate

    logic [TOK_W-1:0]    a_tok;
    logic [TOK_W-1:0]    b_tok;
    logic [DATA_W-1:0]   a_data;
    logic [DATA_W-1:0]   b_data;
    logic                a_last;
    logic [2*DATA_W-1:0] product;
    logic [DATA_W-1:0]   acc_sum;
    logic [DATA_W-1:0]   result;
    logic                unused_bits;

    assign a_tok      = head_tok[src_a_reg];
    assign b_tok      = head_tok[src_b_reg];
    assign a_data     = a_tok[DATA_W-1:0];
    assign a_last     = a_tok[TOK_W-2];
    assign b_data     = use_const_reg ? const_reg : b_tok[DATA_W-1:0];
    assign opnd_ready = !empty[src_a_reg] && (use_const_reg || !empty[src_b_reg]);
    assign down_ready = &Post_PE_Bp;
    assign fire       = (state_reg == RUN) && !cfg_ctrl && opnd_ready && down_ready;
    assign product    = a_data * b_data;
    assign acc_sum    = acc_reg + a_data;
    assign unused_bits = ^{a_tok[TOK_W-1], a_tok[TOK_W-3:DATA_W],
                           b_tok[TOK_W-1:DATA_W], product[2*DATA_W-1:DATA_W]};

    // ALU; accumulate is handled in the sequential block, 11-15 fall to pass A.
    always_comb begin
        result = a_data;
        case (op_reg)
            4'd1:    result = a_data + b_data;
            4'd2:    result = a_data - b_data;
            4'd3:    result = product[DATA_W-1:0];
            4'd4:    result = a_data & b_data;
            4'd5:    result = a_data | b_data;
            4'd6:    result = a_data ^ b_data;
            4'd7:    result = a_data << b_data[4:0];
            4'd8:    result = a_data >> b_data[4:0];
            4'd9:    result = ($signed(a_data) > $signed(b_data)) ? a_data : b_data;
            4'd10:   result = ($signed(a_data) < $signed(b_data)) ? a_data : b_data;
            default: result = a_data;
        endcase
    end

    // Configuration FSM, repeat counting, accumulator and registered output token.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= CFG_IDLE;
            src_a_reg     <= '0;
            src_b_reg     <= '0;
            use_const_reg <= 1'b0;
            rep_reg       <= '0;
            op_reg        <= '0;
            tag_reg       <= '0;
            const_reg     <= '0;
            acc_reg       <= '0;
            fire_cnt_reg  <= '0;
            out_reg       <= '0;
            done_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            out_reg <= '0;
            ovf_reg <= ovf_reg | (|ovf_hit);
            case (state_reg)
                CFG_CONST: begin
                    if (cfg_valid) begin
                        const_reg <= PE_Configure_Inport[DATA_W-1:0];
                        state_reg <= RUN;
                    end
                end
                default: begin
                    if (cfg_ctrl) begin
                        src_a_reg     <= PE_Configure_Inport[24:23];
                        src_b_reg     <= PE_Configure_Inport[22:21];
                        use_const_reg <= PE_Configure_Inport[20];
                        rep_reg       <= PE_Configure_Inport[19:15];
                        op_reg        <= PE_Configure_Inport[14:11];
                        tag_reg       <= PE_Configure_Inport[10:9];
                        acc_reg       <= '0;
                        fire_cnt_reg  <= '0;
                        done_reg      <= 1'b0;
                        state_reg     <= PE_Configure_Inport[20] ? CFG_CONST : RUN;
                    end else if (fire) begin
                        fire_cnt_reg <= fire_cnt_reg + 1'b1;
                        if ((rep_reg != '0) && ((fire_cnt_reg + 5'd1) == rep_reg)) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end
                        if (op_reg == OP_ACC) begin
                            if (a_last) begin
                                out_reg <= {1'b1, 1'b1, tag_reg, acc_sum};
                                acc_reg <= '0;
                            end else begin
                                acc_reg <= acc_sum;
                            end
                        end else begin
                            out_reg <= {1'b1, a_last, tag_reg, result};
                        end
                    end
                end
            endcase
        end
    end

`ifdef PE_STATS_EN
    logic [31:0] fire_stat_reg;
    logic [31:0] stall_stat_reg;
    logic        stall;

    assign stall = (state_reg == RUN) && !cfg_ctrl && opnd_ready && !down_ready;

    // Saturating activity counters, restarted by each new control word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fire_stat_reg  <= '0;
            stall_stat_reg <= '0;
        end else if (cfg_ctrl) begin
            fire_stat_reg  <= '0;
            stall_stat_reg <= '0;
        end else begin
            if (fire && (fire_stat_reg != '1))
                fire_stat_reg <= fire_stat_reg + 1'b1;
            if (stall && (stall_stat_reg != '1))
                stall_stat_reg <= stall_stat_reg + 1'b1;
        end
    end

    assign PE_Fire_Cnt  = fire_stat_reg;
    assign PE_Stall_Cnt = stall_stat_reg;
`endif

    assign PE_Outport = out_reg;
    assign PE_Done    = done_reg;
    assign PE_Ovf     = ovf_reg;

endmodule

// File: tb/tb_pe_param.sv
// tb_pe_param: directed-vector bench for pe_param with hand-computed results.
module tb_pe_param;

    localparam int DATA_W   = 32;
    localparam int TOK_W    = DATA_W + 4;
    localparam int NUM_IN   = 3;
    localparam int NUM_POST = 8;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic [NUM_IN*TOK_W-1:0] PE_Inport = '0;
    logic [NUM_POST-1:0]     Post_PE_Bp = '1;
    logic [32:0]             PE_Configure_Inport = '0;
    logic [TOK_W-1:0]        PE_Outport;
    logic [NUM_IN-1:0]       Pre_PE_Bp;
    logic                    PE_Done;
    logic                    PE_Ovf;
`ifdef PE_STATS_EN
    logic [31:0]             PE_Fire_Cnt;
    logic [31:0]             PE_Stall_Cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    pe_param #(
        .DATA_W(DATA_W), .TOK_W(TOK_W), .NUM_IN(NUM_IN),
        .FIFO_DEPTH(4), .NUM_POST(NUM_POST)
    ) dut (
        .clk(clk),
        .reset(reset),
        .PE_Inport(PE_Inport),
        .Post_PE_Bp(Post_PE_Bp),
        .PE_Configure_Inport(PE_Configure_Inport),
        .PE_Outport(PE_Outport),
        .Pre_PE_Bp(Pre_PE_Bp),
        .PE_Done(PE_Done),
        .PE_Ovf(PE_Ovf)
`ifdef PE_STATS_EN
        ,
        .PE_Fire_Cnt(PE_Fire_Cnt),
        .PE_Stall_Cnt(PE_Stall_Cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ctrl(input logic [1:0] sa, input logic [1:0] sb,
                                         input logic uc, input logic [4:0] r,
                                         input logic [3:0] op, input logic [1:0] tg);
        logic [31:0] w;
        w = '0;
        w[24:23] = sa;
        w[22:21] = sb;
        w[20]    = uc;
        w[19:15] = r;
        w[14:11] = op;
        w[10:9]  = tg;
        return w;
    endfunction

    function automatic logic [TOK_W-1:0] tok(input logic last, input logic [1:0] tg,
                                             input logic [31:0] d);
        return {1'b1, last, tg, d};
    endfunction

    task automatic cfg(input logic [31:0] w, input logic has_const, input logic [31:0] c);
        PE_Configure_Inport = {1'b1, w};
        tick();
        if (has_const) begin
            PE_Configure_Inport = {1'b1, c};
            tick();
        end
        PE_Configure_Inport = '0;
    endtask

    task automatic drive(input int p, input logic [TOK_W-1:0] t);
        PE_Inport[p*TOK_W +: TOK_W] = t;
    endtask

    task automatic idle();
        PE_Inport = '0;
    endtask

    // Opcode vectors: A = -10 (FFFFFFF6), B = constant 3.
    logic [3:0]  op_tab  [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                                  4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12};
    logic [31:0] exp_tab [12] = '{32'hFFFFFFF6, 32'hFFFFFFF9, 32'hFFFFFFF3, 32'hFFFFFFE2,
                                  32'h00000002, 32'hFFFFFFF7, 32'hFFFFFFF5, 32'hFFFFFFB0,
                                  32'h1FFFFFFE, 32'h00000003, 32'hFFFFFFF6, 32'hFFFFFFF6};

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int got;
        int hold_outs;
        logic min_bp;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", PE_Outport, '0);
        check("rst_bp", Pre_PE_Bp, 3'b111);
        check("rst_done", PE_Done, 1'b0);
        check("rst_ovf", PE_Ovf, 1'b0);
        reset = 1'b1;
        tick();

        // ---------------- add with constant, R=3 ----------------
        cfg(ctrl(2'd0, 2'd0, 1'b1, 5'd3, 4'd1, 2'd2), 1'b1, 32'd5);
        for (int i = 0; i < 3; i++) begin
            drive(0, tok(i == 2, 2'd0, 32'(10 * (i + 1))));
            tick();
            idle();
            tick();
            check("add_out", PE_Outport, tok(i == 2, 2'd2, 32'(10 * (i + 1) + 5)));
            if (i < 2)
                check("add_not_done", PE_Done, 1'b0);
        end
        check("add_done", PE_Done, 1'b1);
        tick();
        check("add_pulse", PE_Outport, '0);
        drive(0, tok(1'b0, 2'd0, 32'd40));
        tick();
        idle();
        tick();
        check("done_no_fire", PE_Outport, '0);
        tick();
        check("done_no_fire2", PE_Outport, '0);

        // ---------------- subtract, two ports ----------------
        cfg(ctrl(2'd0, 2'd1, 1'b0, 5'd0, 4'd2, 2'd1), 1'b0, 32'd0);
        check("cfg_clears_done", PE_Done, 1'b0);
        drive(0, tok(1'b0, 2'd0, 32'd7));
        tick();
        idle();
        tick();
        check("sub_wait_b", PE_Outport, '0);
        tick();
        drive(1, tok(1'b0, 2'd0, 32'd2));
        tick();
        idle();
        check("sub_wait_head", PE_Outport, '0);
        tick();
        check("sub_out", PE_Outport, tok(1'b0, 2'd1, 32'd5));

        // ---------------- downstream backpressure ----------------
        cfg(ctrl(2'd0, 2'd0, 1'b1, 5'd0, 4'd0, 2'd0), 1'b1, 32'd0);
        sent = 0;
        got = 0;
        hold_outs = 0;
        min_bp = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (PE_Outport[TOK_W-1]) begin
                if (cyc <= 6)
                    hold_outs++;
                check("bp_order", PE_Outport, tok(1'b0, 2'd0, 32'(100 + got)));
                got++;
            end
            if (cyc < 6 && !Pre_PE_Bp[0])
                min_bp = 1'b0;
            Post_PE_Bp = (cyc < 6) ? 8'hF7 : 8'hFF;
            if (sent < 8 && Pre_PE_Bp[0]) begin
                drive(0, tok(1'b0, 2'd0, 32'(100 + sent)));
                sent++;
            end else begin
                idle();
            end
            tick();
        end
        idle();
        Post_PE_Bp = '1;
        check("bp_hold_outputs", 64'(hold_outs), 64'd0);
        check("bp_drop", min_bp, 1'b0);
        check("bp_count", 64'(got), 64'd8);
        check("bp_no_ovf", PE_Ovf, 1'b0);

        // ---------------- overflow ----------------
        cfg(ctrl(2'd0, 2'd1, 1'b0, 5'd0, 4'd1, 2'd0), 1'b0, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            drive(0, tok(1'b0, 2'd0, 32'(i)));
            tick();
            if (i == 4) begin
                check("ovf_before", PE_Ovf, 1'b0);
                check("ovf_full_bp", Pre_PE_Bp[0], 1'b0);
            end
        end
        idle();
        check("ovf_set", PE_Ovf, 1'b1);
        got = 0;
        for (int j = 0; j < 10; j++) begin
            if (PE_Outport[TOK_W-1]) begin
                check("ovf_drain", PE_Outport, tok(1'b0, 2'd0, 32'(1001 + got)));
                got++;
            end
            if (j < 5)
                drive(1, tok(1'b0, 2'd0, 32'd1000));
            else
                idle();
            tick();
        end
        check("ovf_dropped", 64'(got), 64'd4);

        // ---------------- accumulate ----------------
        cfg(ctrl(2'd0, 2'd0, 1'b1, 5'd0, 4'd11, 2'd3), 1'b1, 32'd0);
        check("ovf_sticky", PE_Ovf, 1'b1);
        got = 0;
        for (int j = 0; j < 8; j++) begin
            if (PE_Outport[TOK_W-1]) begin
                check("acc_out", PE_Outport, tok(1'b1, 2'd3, 32'd6));
                got++;
            end
            if (j < 3)
                drive(0, tok(j == 2, 2'd0, 32'(j + 1)));
            else
                idle();
            tick();
        end
        check("acc_count", 64'(got), 64'd1);
        drive(0, tok(1'b1, 2'd0, 32'd4));
        tick();
        idle();
        tick();
        check("acc_cleared", PE_Outport, tok(1'b1, 2'd3, 32'd4));

        // ---------------- opcode table ----------------
        for (int i = 0; i < 12; i++) begin
            logic [3:0] op;
            op = op_tab[i];
            cfg(ctrl(2'd0, 2'd0, 1'b1, 5'd0, op, op[1:0]), 1'b1, 32'd3);
            drive(0, tok(1'b0, 2'd0, 32'hFFFFFFF6));
            tick();
            idle();
            tick();
            check($sformatf("op%0d", op), PE_Outport, tok(1'b0, op[1:0], exp_tab[i]));
        end

        // ---------------- asynchronous reset mid-stream ----------------
        cfg(ctrl(2'd0, 2'd0, 1'b1, 5'd0, 4'd0, 2'd1), 1'b1, 32'd0);
        drive(1, tok(1'b0, 2'd0, 32'd9));
        tick();
        tick();
        drive(0, tok(1'b0, 2'd0, 32'd77));
        tick();
        idle();
        tick();
        check("rst_pre_out", PE_Outport, tok(1'b0, 2'd1, 32'd77));
        check("rst_pre_bp", Pre_PE_Bp, 3'b101);
        #2;
        reset = 1'b0;
        #1;
        check("arst_out", PE_Outport, '0);
        check("arst_bp", Pre_PE_Bp, 3'b111);
        check("arst_ovf", PE_Ovf, 1'b0);
        check("arst_done", PE_Done, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        got = 0;
        for (int j = 0; j < 8; j++) begin
            if (PE_Outport[TOK_W-1])
                got++;
            if (j < 4)
                drive(0, tok(1'b0, 2'd0, 32'(200 + j)));
            else
                idle();
            tick();
        end
        check("idle_no_output", 64'(got), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
